// File: rtl/tdc_stream_framer.sv
// TDC record framer: wraps each tlast-delimited byte record as SYNC, TYPE, SEQ,
// payload (zero-padded or truncated to PAYLOAD_BYTES) and a zero-sum checksum.
//
// state    | meaning
// IDLE     | waiting for the first byte of a record
// HDR_SYNC | emit sync byte (only if the output register was busy at record start)
// HDR_TYPE | emit message type
// HDR_SEQ  | emit sequence number
// PAYLOAD  | pass record bytes through into the frame
// PAD      | zero-fill after an early tlast
// CHK      | emit checksum with tlast
// DISCARD  | drop the tail of an overlong record
module tdc_stream_framer #(
   parameter int unsigned PAYLOAD_BYTES = 12,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter logic [7:0]  MSG_TYPE      = 8'h01
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_s_axis_tdata,
   input  logic       i_s_axis_tvalid,
   output logic       o_s_axis_tready,
   input  logic       i_s_axis_tlast,
   output logic [7:0] o_m_axis_tdata,
   output logic       o_m_axis_tvalid,
   input  logic       i_m_axis_tready,
   output logic       o_m_axis_tlast,
   output logic [7:0] o_err_count,
   output logic [7:0] o_seq
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR_SYNC, S_HDR_TYPE, S_HDR_SEQ, S_PAYLOAD, S_PAD, S_CHK, S_DISCARD
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

   state_t     state, state_nxt;
   logic [7:0] sum, sum_nxt;
   logic [7:0] idx, idx_nxt;
   logic [7:0] seq, seq_nxt;
   logic [7:0] err_cnt, err_nxt, err_inc;
   logic       late, late_nxt;
   logic       out_valid, out_last;
   logic [7:0] out_data;
   logic       can_load, load, load_last, s_ready;
   logic [7:0] load_data;

   assign can_load = !out_valid || i_m_axis_tready;
   assign err_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

   always_comb begin
      state_nxt = state;
      sum_nxt   = sum;
      idx_nxt   = idx;
      seq_nxt   = seq;
      err_nxt   = err_cnt;
      late_nxt  = late;
      load      = 1'b0;
      load_data = 8'h00;
      load_last = 1'b0;
      s_ready   = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_s_axis_tvalid) begin
               sum_nxt  = 8'h00;
               idx_nxt  = 8'h00;
               late_nxt = 1'b0;
               // Emit sync straight away when possible so the header follows tvalid by one cycle
               if (can_load) begin
                  load      = 1'b1;
                  load_data = SYNC_BYTE;
                  state_nxt = S_HDR_TYPE;
               end else begin
                  state_nxt = S_HDR_SYNC;
               end
            end
         end
         S_HDR_SYNC: begin
            if (can_load) begin
               load      = 1'b1;
               load_data = SYNC_BYTE;
               state_nxt = S_HDR_TYPE;
            end
         end
         S_HDR_TYPE: begin
            if (can_load) begin
               load      = 1'b1;
               load_data = MSG_TYPE;
               sum_nxt   = sum + MSG_TYPE;
               state_nxt = S_HDR_SEQ;
            end
         end
         S_HDR_SEQ: begin
            if (can_load) begin
               load      = 1'b1;
               load_data = seq;
               sum_nxt   = sum + seq;
               state_nxt = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            s_ready = can_load;
            if (i_s_axis_tvalid && can_load) begin
               load      = 1'b1;
               load_data = i_s_axis_tdata;
               sum_nxt   = sum + i_s_axis_tdata;
               idx_nxt   = idx + 8'd1;
               if (idx == LAST_IDX) begin
                  state_nxt = S_CHK;
                  late_nxt  = !i_s_axis_tlast;
               end else if (i_s_axis_tlast) begin
                  state_nxt = S_PAD;
                  err_nxt   = err_inc;
               end
            end
         end
         S_PAD: begin
            if (can_load) begin
               load    = 1'b1;
               idx_nxt = idx + 8'd1;
               if (idx == LAST_IDX) state_nxt = S_CHK;
            end
         end
         S_CHK: begin
            if (can_load) begin
               load      = 1'b1;
               load_data = 8'h00 - sum;
               load_last = 1'b1;
               seq_nxt   = seq + 8'd1;
               if (late) begin
                  state_nxt = S_DISCARD;
                  err_nxt   = err_inc;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_DISCARD: begin
            s_ready = 1'b1;
            if (i_s_axis_tvalid && i_s_axis_tlast) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         sum       <= 8'h00;
         idx       <= 8'h00;
         seq       <= 8'h00;
         err_cnt   <= 8'h00;
         late      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_last  <= 1'b0;
      end else begin
         state   <= state_nxt;
         sum     <= sum_nxt;
         idx     <= idx_nxt;
         seq     <= seq_nxt;
         err_cnt <= err_nxt;
         late    <= late_nxt;
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
         end else if (i_m_axis_tready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign o_s_axis_tready = s_ready;
   assign o_m_axis_tdata  = out_data;
   assign o_m_axis_tvalid = out_valid;
   assign o_m_axis_tlast  = out_last;
   assign o_err_count     = err_cnt;
   assign o_seq           = seq;

endmodule
